// File: rtl/vram_rect_fill_8_pkg.sv
// Shared constants and FSM encoding for the VRAM rectangle filler.
package vram_rect_fill_8_pkg;
   localparam int C_COORD_WIDTH = 6;     // bits per axis (64x64 VRAM)
   localparam int C_DATA_WIDTH  = 8;     // RGB332 pixel
   localparam int C_VRAM_SIZE   = 4096;  // bytes

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_FILL    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;
endpackage

// File: rtl/vram_rect_fill_8_vsync_edge.sv
// Registers vsync and flags its 1->0 transition (start of the blanking pulse).
module vsync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic vsync_i,
   output logic fall_o
);
   logic vs_q;

   // Previous vsync level; resets low so a reset never fakes a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vs_q <= 1'b0;
      else       vs_q <= vsync_i;
   end

   assign fall_o = vs_q & ~vsync_i;
endmodule

// File: rtl/vram_rect_fill_8.sv
// Clipped rectangle fill into a 64x64 byte VRAM, one pixel write per cycle,
// optionally deferred to the next vsync falling edge.
module vram_rect_fill_8 #(
   parameter int C_COORD_WIDTH = vram_rect_fill_8_pkg::C_COORD_WIDTH,
   parameter int C_DATA_WIDTH  = vram_rect_fill_8_pkg::C_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [C_COORD_WIDTH-1:0]       x0,
   input  logic [C_COORD_WIDTH-1:0]       y0,
   input  logic [C_COORD_WIDTH:0]         w,
   input  logic [C_COORD_WIDTH:0]         h,
   input  logic [C_DATA_WIDTH-1:0]        color,
   input  logic                           use_vsync,
   input  logic                           vsync,
   output logic                           busy,
   output logic                           done,
   output logic signed [31:0]             data_address,
   output logic signed [C_DATA_WIDTH-1:0] data_din,
   output logic                           data_we
);
   import vram_rect_fill_8_pkg::*;

   localparam int CW = C_COORD_WIDTH;
   localparam int DW = C_DATA_WIDTH;
   // Number of pixels per axis, expressed in the (CW+1)-bit length width.
   localparam logic [CW:0] SPAN = {1'b1, {CW{1'b0}}};

   // Length clipped to the pixels remaining before the right/bottom edge.
   function automatic logic [CW:0] clip_len(input logic [CW-1:0] pos, input logic [CW:0] len);
      logic [CW:0] room;
      room = SPAN - {1'b0, pos};
      return (len < room) ? len : room;
   endfunction

   function automatic logic [31:0] pix_addr(input logic [CW-1:0] y, input logic [CW-1:0] x);
      return {{(32-2*CW){1'b0}}, y, x};
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   x0_q, x0_d, y0_q, y0_d;
   logic [CW:0]     w_q, w_d, h_q, h_d;
   logic [DW-1:0]   color_q, color_d;
   logic            use_vs_q, use_vs_d;
   // Offset of the pixel currently presented on the write port.
   logic [CW:0]     col_q, col_d, row_q, row_d;
   logic [31:0]     addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic            we_q, we_d;
   logic            vs_fall;
   logic [CW:0]     eff_w, eff_h;

   vsync_edge_detect u_vs_edge (
      .clk     (clk),
      .reset   (reset),
      .vsync_i (vsync),
      .fall_o  (vs_fall)
   );

   assign eff_w = clip_len(x0_q, w_q);
   assign eff_h = clip_len(y0_q, h_q);

   // Next-state and next-write decode; the first pixel is loaded on the edge
   // that leaves IDLE/WAIT_VS so it is on the bus in the first FILL cycle.
   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      w_d      = w_q;
      h_d      = h_q;
      color_d  = color_q;
      use_vs_d = use_vs_q;
      col_d    = col_q;
      row_d    = row_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x0_d     = x0;
               y0_d     = y0;
               w_d      = w;
               h_d      = h;
               color_d  = color;
               use_vs_d = use_vsync;
               col_d    = '0;
               row_d    = '0;
               if (w == '0 || h == '0) begin
                  state_d = ST_DONE;
               end else if (use_vsync) begin
                  state_d = ST_WAIT_VS;
               end else begin
                  state_d = ST_FILL;
                  we_d    = 1'b1;
                  addr_d  = pix_addr(y0, x0);
                  din_d   = color;
               end
            end
         end
         ST_WAIT_VS: begin
            // use_vs_q is always set in this state; the edge is what matters.
            if (use_vs_q && vs_fall) begin
               state_d = ST_FILL;
               we_d    = 1'b1;
               addr_d  = pix_addr(y0_q, x0_q);
               din_d   = color_q;
            end
         end
         ST_FILL: begin
            if (col_q == eff_w - 1'b1) begin
               if (row_q == eff_h - 1'b1) begin
                  state_d = ST_DONE;
               end else begin
                  col_d  = '0;
                  row_d  = row_q + 1'b1;
                  we_d   = 1'b1;
                  addr_d = pix_addr(y0_q + row_d[CW-1:0], x0_q);
               end
            end else begin
               col_d  = col_q + 1'b1;
               we_d   = 1'b1;
               addr_d = pix_addr(y0_q + row_q[CW-1:0], x0_q + col_d[CW-1:0]);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, latched command and registered write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         color_q  <= '0;
         use_vs_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         color_q  <= color_d;
         use_vs_q <= use_vs_d;
         col_q    <= col_d;
         row_q    <= row_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         we_q     <= we_d;
      end
   end

   assign busy         = (state_q == ST_WAIT_VS) || (state_q == ST_FILL);
   assign done         = (state_q == ST_DONE);
   assign data_address = addr_q;
   assign data_din     = din_q;
   assign data_we      = we_q;
endmodule

// File: tb/tb_vram_rect_fill_8.sv
// Self-checking bench: directed and random rectangle fills against a
// pixel-list reference model.
module tb_vram_rect_fill_8;
   logic              clk = 1'b0;
   logic              reset, start, use_vsync, vsync;
   logic [5:0]        x0, y0;
   logic [6:0]        w, h;
   logic [7:0]        color;
   logic              busy, done, data_we;
   logic signed [31:0] data_address;
   logic signed [7:0]  data_din;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vram_rect_fill_8 dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .x0           (x0),
      .y0           (y0),
      .w            (w),
      .h            (h),
      .color        (color),
      .use_vsync    (use_vsync),
      .vsync        (vsync),
      .busy         (busy),
      .done         (done),
      .data_address (data_address),
      .data_din     (data_din),
      .data_we      (data_we)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Issue one command and check every write, busy/done timing against the model.
   // vd: cycle index at which vsync drops; dbl: cycle index of a stray start (-1 none).
   task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch,
                          input logic [7:0] col, input logic uv, input int vd, input int dbl);
      logic [31:0] exp_a[$];
      logic [31:0] got_a[$];
      logic [7:0]  got_d[$];
      logic [7:0]  dv;
      logic [5:0]  cx6, cy6;
      logic [6:0]  cw7, ch7;
      int idx, first_idx, done_idx, busy_cnt, done_cnt, post, n, lat0;
      for (int yy = cy0; yy < cy0 + ch && yy < 64; yy++)
         for (int xx = cx0; xx < cx0 + cw && xx < 64; xx++)
            exp_a.push_back(32'(yy * 64 + xx));
      n = exp_a.size();
      lat0 = uv ? vd + 1 : 1;
      cx6 = cx0[5:0]; cy6 = cy0[5:0]; cw7 = cw[6:0]; ch7 = ch[6:0];
      @(negedge clk);
      x0 = cx6; y0 = cy6; w = cw7; h = ch7; color = col; use_vsync = uv;
      vsync = 1'b1; start = 1'b1;
      idx = 0; first_idx = -1; done_idx = -1; busy_cnt = 0; done_cnt = 0; post = 0;
      while (idx < n + vd + 50 && post < 3) begin
         @(negedge clk);
         idx++;
         if (data_we) begin
            if (first_idx < 0) first_idx = idx;
            got_a.push_back(data_address);
            dv = data_din;
            got_d.push_back(dv);
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = idx;
         end
         if (done_idx >= 0) post++;
         start = (idx == dbl);
         if (uv && idx == vd) vsync = 1'b0;
      end
      start = 1'b0;
      vsync = 1'b1;
      chk("write_count", got_a.size(), n);
      for (int i = 0; i < n && i < got_a.size(); i++) begin
         chk("addr", got_a[i], exp_a[i]);
         chk("din", {24'd0, got_d[i]}, {24'd0, col});
      end
      chk("done_pulses", done_cnt, 1);
      chk("busy_cycles", busy_cnt, (n > 0) ? n + (uv ? vd : 0) : 0);
      if (n > 0) begin
         chk("first_write", first_idx, lat0);
         chk("done_at", done_idx, lat0 + n);
      end else begin
         chk("done_at", done_idx, 1);
      end
   endtask

   initial begin
      int wr, dn, rx, ry, rw, rh, rvd;
      logic ruv;
      reset = 1'b1; start = 1'b0; use_vsync = 1'b0; vsync = 1'b1;
      x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", data_we, 0);
      chk("rst_addr", data_address, 0);
      chk("rst_din", {24'd0, data_din}, 0);
      reset = 1'b0;
      @(negedge clk);

      run_cmd(2, 3, 4, 2, 8'hA5, 1'b0, 0, -1);      // basic 4x2
      run_cmd(62, 63, 5, 3, 8'h3C, 1'b0, 0, -1);    // clipped corner
      run_cmd(5, 5, 0, 10, 8'h11, 1'b0, 0, -1);     // zero width
      run_cmd(7, 9, 3, 0, 8'h22, 1'b1, 4, -1);      // zero height, vsync mode
      run_cmd(10, 20, 3, 2, 8'h5A, 1'b1, 20, -1);   // vsync deferred
      run_cmd(0, 0, 4, 4, 8'hC3, 1'b0, 0, 3);       // stray start during fill
      run_cmd(10, 63, 127, 1, 8'hFF, 1'b0, 0, -1);  // oversize width clipped
      run_cmd(0, 0, 64, 64, 8'h81, 1'b0, 0, -1);    // full screen

      // Reset in the middle of a full-screen fill.
      @(negedge clk);
      x0 = 6'd0; y0 = 6'd0; w = 7'd64; h = 7'd64; color = 8'h77; use_vsync = 1'b0;
      start = 1'b1;
      wr = 0;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
         if (data_we) wr++;
      end
      chk("pre_reset_writes", wr, 3);
      reset = 1'b1;
      #1;
      chk("abort_we", data_we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_addr", data_address, 0);
      @(negedge clk);
      reset = 1'b0;
      wr = 0; dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (data_we) wr++;
         if (done) dn++;
      end
      chk("post_abort_writes", wr, 0);
      chk("post_abort_done", dn, 0);
      run_cmd(0, 0, 1, 1, 8'h42, 1'b0, 0, -1);

      // Random commands, biased toward the right/bottom edges half the time.
      for (int k = 0; k < 14; k++) begin
         rx  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(48, 63));
         ry  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(48, 63));
         rw  = $urandom_range(0, 24);
         rh  = $urandom_range(0, 24);
         ruv = 1'($urandom_range(0, 1));
         rvd = $urandom_range(1, 12);
         run_cmd(rx, ry, rw, rh, 8'($urandom), ruv, rvd, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vram_rect_fill_8.md
VRAM_RECT_FILL_8 -- requirements
Module: vram_rect_fill_8

Interface
REQ-001 Parameter C_COORD_WIDTH, default 6: bits per axis; VRAM is 64x64 pixels, 4096 bytes.
REQ-002 Parameter C_DATA_WIDTH, default 8: pixel width, RGB332.
REQ-003 clk  in  1: single clock; all logic on its rising edge.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 start  in  1: one-cycle command strobe.
REQ-006 x0, y0  in  6 each: top-left corner, unsigned.
REQ-007 w, h  in  7 each: width and height in pixels, 0..64.
REQ-008 color  in  8: fill value.
REQ-009 use_vsync  in  1: 1 = defer fill until the vsync falling edge.
REQ-010 vsync  in  1: active-low vertical sync, already in the clk domain (vga_vram_8 vsync output).
REQ-011 busy  out  1: command in progress.
REQ-012 done  out  1: one-cycle completion pulse.
REQ-013 data_address  out  32 signed: VRAM write address, {20'b0, y[5:0], x[5:0]}.
REQ-014 data_din  out  8 signed: write data.
REQ-015 data_we  out  1: write strobe, one byte per asserted cycle.

Function
REQ-016 The block SHALL hold FSM states IDLE, WAIT_VS, FILL and DONE.
REQ-017 IDLE + start=1 SHALL latch x0, y0, w, h, color and use_vsync, then go to WAIT_VS if use_vsync=1, otherwise to FILL; if w=0 or h=0 it SHALL go to DONE.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 Clip: effective width = min(w, 64-x0) and effective height = min(h, 64-y0); writes SHALL never wrap, and the clip arithmetic SHALL use 7-bit widths.
REQ-020 WAIT_VS SHALL register vsync and leave for FILL on the cycle a 1->0 transition is detected.
REQ-021 FILL SHALL issue exactly one write per cycle in raster order: x increments first, then y increments and x resets to x0.
REQ-022 The first write SHALL appear in the cycle after start is sampled when use_vsync=0, and in the cycle after the edge is detected when use_vsync=1.
REQ-023 data_address, data_din and data_we SHALL be registered outputs; data_we=0 outside FILL.
REQ-024 After the last write, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in WAIT_VS and FILL and 0 in IDLE and DONE.
REQ-026 Throughput SHALL be effective width x effective height cycles of FILL per command, with no stalls.

Reset
REQ-027 Reset SHALL force IDLE, busy=0, done=0, data_we=0, data_address=0, data_din=0 and clear all latched fields.
REQ-028 Reset asserted mid-fill SHALL abort the fill at once, with no further writes and no done pulse.
REQ-029 After reset deasserts, the next start SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold C_COORD_WIDTH, C_DATA_WIDTH, C_VRAM_SIZE=4096 and the FSM state encoding constants.
REQ-031 One sub-module, vsync_edge_detect (register plus falling-edge pulse), SHALL be instantiated; the counters and FSM SHALL stay in the top module.

Verification
REQ-032 x0=2, y0=3, w=4, h=2, color=0xA5, use_vsync=0 -> 8 writes to 194..197 then 258..261, data_din=0xA5, busy high 8 cycles, done 1 cycle later.
REQ-033 x0=62, y0=63, w=5, h=3 -> exactly 2 writes, to 4094 and 4095, then done.
REQ-034 w=0, h=10 -> no writes, done in the cycle after start, busy never high.
REQ-035 use_vsync=1 with vsync high 20 cycles then low -> busy during the wait, no writes before the edge, first write 1 cycle after the edge is detected.
REQ-036 Reset after the 3rd write of a 64x64 fill -> data_we low immediately, no done pulse; a following 1x1 fill at (0,0) writes address 0 once.
REQ-037 Second start pulse during FILL of a 4x4 rectangle -> ignored: 16 writes only, one done pulse.
